font_pixel_serializer: RTL

Consumes the font-ROM row word returned for the ROM address issued by the character-address generator and serializes it into the per-pixel RGB stream for the VGA output stage. It re-aligns pixel position and `video_on` with the ROM read latency, selects the font bit, and applies foreground/background colours. Colour changes are double-buffered per frame. An optional blinking text cursor is supported.

---
 rtl/font_pixel_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/font_pixel_serializer.sv
// Font row serializer: delays pixel side-channel by the ROM latency, picks the font bit and
// applies frame-buffered fg/bg colours. Optional blinking cursor under `CURSOR_BLINK_EN.
module font_pixel_serializer #(
   parameter int unsigned ROM_LAT      = 1,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter logic [2:0]  FG_RESET     = 3'b111,
   parameter logic [2:0]  BG_RESET     = 3'b000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       video_on,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic [7:0] font_word,
   input  logic       col_we,
   input  logic       col_sel,
   input  logic [2:0] col_data,
   input  logic [6:0] cur_col,
   input  logic [5:0] cur_row,
   output logic [2:0] rgb,
   output logic       frame_tick
);

   localparam int unsigned BAW  = 3;
   localparam int unsigned COLW = 7;
   localparam int unsigned ROWW = 6;
   localparam int unsigned RGBW = 3;

   logic [BAW-1:0]  ba_q  [ROM_LAT];
   logic            von_q [ROM_LAT];
   logic [COLW-1:0] col_q [ROM_LAT];
   logic [ROWW-1:0] row_q [ROM_LAT];

   logic [BAW-1:0]  ba_dly;
   logic            von_dly;
   logic [COLW-1:0] col_dly;
   logic [ROWW-1:0] row_dly;

   logic            at0_c;
   logic            at0_q;
   logic            frame_tick_d, frame_tick_q;
   logic [RGBW-1:0] rgb_d, rgb_q;
   logic [RGBW-1:0] fg_sh_q, bg_sh_q, fg_act_q, bg_act_q;
   logic            inv_c;
   logic            pix_c;
   logic [RGBW-1:0] fg_use_c, bg_use_c;

   // Side-channel pipeline matching the font ROM read latency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(ROM_LAT); i++) begin
            ba_q[i]  <= '0;
            von_q[i] <= 1'b0;
            col_q[i] <= '0;
            row_q[i] <= '0;
         end
      end else begin
         ba_q[0]  <= pixel_x[2:0];
         von_q[0] <= video_on;
         col_q[0] <= pixel_x[9:3];
         row_q[0] <= pixel_y[9:4];
         for (int i = 1; i < int'(ROM_LAT); i++) begin
            ba_q[i]  <= ba_q[i-1];
            von_q[i] <= von_q[i-1];
            col_q[i] <= col_q[i-1];
            row_q[i] <= row_q[i-1];
         end
      end
   end

   assign ba_dly  = ba_q[ROM_LAT-1];
   assign von_dly = von_q[ROM_LAT-1];
   assign col_dly = col_q[ROM_LAT-1];
   assign row_dly = row_q[ROM_LAT-1];

   assign at0_c        = (pixel_x == '0) && (pixel_y == '0);
   assign frame_tick_d = at0_c & ~at0_q;

   // Shadow colours written any time; promoted to active only at frame start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fg_sh_q  <= FG_RESET;
         bg_sh_q  <= BG_RESET;
         fg_act_q <= FG_RESET;
         bg_act_q <= BG_RESET;
      end else begin
         if (col_we && !col_sel) fg_sh_q <= col_data;
         if (col_we &&  col_sel) bg_sh_q <= col_data;
         if (frame_tick_q) begin
            fg_act_q <= fg_sh_q;
            bg_act_q <= bg_sh_q;
         end
      end
   end

`ifdef CURSOR_BLINK_EN
   localparam int unsigned CNTW = 8;

   logic [CNTW-1:0] blink_cnt_q;
   logic            blink_ph_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
      end else if (frame_tick_q) begin
         if (blink_cnt_q == CNTW'(BLINK_FRAMES - 1)) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= ~blink_ph_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + CNTW'(1);
         end
      end
   end

   assign inv_c = blink_ph_q && (col_dly == cur_col) && (row_dly == cur_row);
`else
   logic unused_cursor_c;
   assign unused_cursor_c = ^{cur_col, cur_row, col_dly, row_dly};
   assign inv_c           = 1'b0;
`endif

   always_comb begin
      pix_c    = font_word[3'd7 - ba_dly];
      fg_use_c = inv_c ? bg_act_q : fg_act_q;
      bg_use_c = inv_c ? fg_act_q : bg_act_q;
      rgb_d    = pix_c ? fg_use_c : bg_use_c;
      if (!von_dly) rgb_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         at0_q        <= 1'b0;
         frame_tick_q <= 1'b0;
         rgb_q        <= '0;
      end else begin
         at0_q        <= at0_c;
         frame_tick_q <= frame_tick_d;
         rgb_q        <= rgb_d;
      end
   end

   assign rgb        = rgb_q;
   assign frame_tick = frame_tick_q;

endmodule
